// File: rtl/tff_count_sequencer.sv
// Control sequencer for a WIDTH-bit T-flop counter bank. It produces the toggle
// vector for each cycle and tracks the start/busy/done handshake with the host.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; bank holds its value (t_vec = 0)
// LOAD  | one cycle: toggle the bits that differ from the captured load value
// RUN   | count up/down each cycle until q matches the captured limit
module tff_count_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             re,
   input  logic             start,
   input  logic             up,
   input  logic             wrap,
   input  logic             halt,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] t_vec,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10
   } state_t;

   state_t           state;
   logic             up_cap;
   logic             wrap_cap;
   logic [WIDTH-1:0] load_cap;
   logic [WIDTH-1:0] limit_cap;

   logic [WIDTH-1:0] t_up;
   logic [WIDTH-1:0] t_dn;
   logic             match;

   assign match = (q == limit_cap);

   // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
   always_comb begin : toggle_calc
      logic run_up;
      logic run_dn;
      run_up = 1'b1;
      run_dn = 1'b1;
      t_up   = '0;
      t_dn   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         t_up[i] = run_up;
         t_dn[i] = run_dn;
         run_up  = run_up & q[i];
         run_dn  = run_dn & ~q[i];
      end
   end

   always_comb begin
      t_vec = '0;
      case (state)
         IDLE: t_vec = '0;
         LOAD: t_vec = q ^ load_cap;
         RUN: begin
            if (halt) begin
               t_vec = '0;
            end else if (match) begin
               t_vec = wrap_cap ? (q ^ load_cap) : '0;
            end else begin
               t_vec = up_cap ? t_up : t_dn;
            end
         end
         default: t_vec = '0;
      endcase
   end

   always_ff @(posedge clk or negedge re) begin
      if (!re) begin
         state     <= IDLE;
         q         <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         up_cap    <= 1'b0;
         wrap_cap  <= 1'b0;
         load_cap  <= '0;
         limit_cap <= '0;
      end else begin
         // The bank is only ever updated through the toggle vector.
         q    <= q ^ t_vec;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  up_cap    <= up;
                  wrap_cap  <= wrap;
                  load_cap  <= load_val;
                  limit_cap <= limit;
                  busy      <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               state <= RUN;
            end
            RUN: begin
               if (!halt && match) begin
                  done <= 1'b1;
                  if (!wrap_cap) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Bench for tff_count_sequencer: directed scenarios plus random stimulus, all
// checked against a cycle-level behavioural model of the counter.
module tb_tff_count_sequencer;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             re;
   logic             start;
   logic             up;
   logic             wrap;
   logic             halt;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: value of the counter and handshake flags
   logic [WIDTH-1:0] m_q;
   logic             m_busy;
   logic             m_done;
   logic             m_loading;
   logic             m_up;
   logic             m_wrap;
   logic [WIDTH-1:0] m_load;
   logic [WIDTH-1:0] m_limit;

   tff_count_sequencer #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .re       (re),
      .start    (start),
      .up       (up),
      .wrap     (wrap),
      .halt     (halt),
      .load_val (load_val),
      .limit    (limit),
      .t_vec    (t_vec),
      .q        (q),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q       = '0;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_loading = 1'b0;
      m_up      = 1'b0;
      m_wrap    = 1'b0;
      m_load    = '0;
      m_limit   = '0;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   task automatic tick();
      logic [WIDTH-1:0] nq;
      logic             nd;
      logic             nb;
      logic             nl;
      logic             cap;
      @(negedge clk);
      nq  = m_q;
      nd  = 1'b0;
      nb  = m_busy;
      nl  = 1'b0;
      cap = 1'b0;
      if (!m_busy) begin
         if (start) begin
            cap = 1'b1;
            nb  = 1'b1;
            nl  = 1'b1;
         end
      end else if (m_loading) begin
         nq = m_load;
      end else if (!halt) begin
         if (m_q == m_limit) begin
            nd = 1'b1;
            if (m_wrap) nq = m_load;
            else nb = 1'b0;
         end else begin
            nq = m_up ? m_q + 1'b1 : m_q - 1'b1;
         end
      end
      check_val("q", q, m_q);
      check_val("busy", busy, m_busy);
      check_val("done", done, m_done);
      check_val("t_vec", t_vec, m_q ^ nq);
      @(posedge clk);
      m_q       = nq;
      m_done    = nd;
      m_busy    = nb;
      m_loading = nl;
      if (cap) begin
         m_up    = up;
         m_wrap  = wrap;
         m_load  = load_val;
         m_limit = limit;
      end
      #1;
   endtask

   task automatic scramble_cfg();
      up       = 1'($urandom);
      wrap     = 1'($urandom);
      load_val = WIDTH'($urandom);
      limit    = WIDTH'($urandom);
   endtask

   task automatic do_start(input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] lim,
                           input logic u, input logic w);
      load_val = lv;
      limit    = lim;
      up       = u;
      wrap     = w;
      start    = 1'b1;
      tick();
      start = 1'b0;
      scramble_cfg();
   endtask

   task automatic async_reset();
      #1 re = 1'b0;
      #1;
      model_reset();
      check_val("rst_q", q, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      #1 re = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int guard;
   int done_cnt;

   initial begin
      re = 1'b0; start = 1'b0; up = 1'b0; wrap = 1'b0; halt = 1'b0;
      load_val = '0; limit = '0;
      model_reset();
      #2;
      check_val("reset_q", q, 0);
      check_val("reset_busy", busy, 0);
      check_val("reset_done", done, 0);
      @(posedge clk); #1 re = 1'b1;
      run(2);

      // 1: up 3..7, stop
      do_start(4'd3, 4'd7, 1'b1, 1'b0);
      run(8);
      check_val("s1_hold_q", q, 7);
      check_val("s1_busy", busy, 0);

      // 2: down 2..E through zero
      do_start(4'd2, 4'hE, 1'b0, 1'b0);
      run(8);
      check_val("s2_hold_q", q, 4'hE);

      // 6: load equals limit
      do_start(4'd9, 4'd9, 1'b1, 1'b0);
      check_val("s6_busy", busy, 1);
      tick();
      check_val("s6_q_load", q, 9);
      tick();
      check_val("s6_done", done, 1);
      check_val("s6_q_hold", q, 9);
      run(2);

      // 3: wrap 5,6,5,6 — count done pulses
      do_start(4'd5, 4'd6, 1'b1, 1'b1);
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) done_cnt++;
      end
      check_val("s3_done_pulses", done_cnt, 5);
      check_val("s3_busy", busy, 1);
      async_reset();
      run(2);

      // 4: halt at q=4 for 3 cycles, start pulses ignored while busy
      do_start(4'd1, 4'd9, 1'b1, 1'b0);
      guard = 0;
      while (m_q != 4 && guard < 20) begin tick(); guard++; end
      check_val("s4_reach4", guard < 20, 1);
      halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; scramble_cfg();
         tick();
      end
      halt = 1'b0; start = 1'b0;
      check_val("s4_q_held", q, 4);
      tick();
      check_val("s4_resume", q, 5);
      run(8);

      // 5: reset mid-run at q=6
      do_start(4'd2, 4'hC, 1'b1, 1'b0);
      guard = 0;
      while (m_q != 6 && guard < 20) begin tick(); guard++; end
      check_val("s5_reach6", guard < 20, 1);
      async_reset();
      run(4);
      check_val("s5_idle_q", q, 0);

      // random stimulus
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(0, 3) == 0);
         halt  = ($urandom_range(0, 5) == 0);
         scramble_cfg();
         tick();
         if ($urandom_range(0, 79) == 0) async_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
